// File: rtl/conv_result_checker.sv
// Watches the 3x3 and 2x2 systolic array output windows after a start pulse, measures
// each array's settle latency and latches a match/mismatch/timeout verdict.
module conv_result_checker #(
  parameter int unsigned DW            = 8,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned TIMEOUT       = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DW-1:0]    a_o00,
  input  logic [DW-1:0]    a_o01,
  input  logic [DW-1:0]    a_o10,
  input  logic [DW-1:0]    a_o11,
  input  logic [DW-1:0]    b_o00,
  input  logic [DW-1:0]    b_o01,
  input  logic [DW-1:0]    b_o10,
  input  logic [DW-1:0]    b_o11,
  output logic             busy,
  output logic             done,
  output logic             match,
  output logic             timeout,
  output logic [3:0]       mismatch_mask,
  output logic [CNT_W-1:0] lat_a,
  output logic [CNT_W-1:0] lat_b
);

  localparam int unsigned STAB_W = 4;
  localparam int unsigned VEC_W  = 4 * DW;
  localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]  CYC_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_next;
  logic [VEC_W-1:0]   cur_a, cur_b, prev_a, prev_b;
  logic [CNT_W-1:0]   cyc, chg_a, chg_b;
  logic [STAB_W-1:0]  stab_a, stab_b;
  logic               settled_a, settled_b;
  logic               do_start, do_finish, do_timeout;
  logic [3:0]         mask_c;

  assign cur_a     = {a_o00, a_o01, a_o10, a_o11};
  assign cur_b     = {b_o00, b_o01, b_o10, b_o11};
  assign settled_a = (stab_a == STAB_MAX);
  assign settled_b = (stab_b == STAB_MAX);
  assign mask_c    = {a_o11 != b_o11, a_o10 != b_o10, a_o01 != b_o01, a_o00 != b_o00};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A start pulse in any state restarts; in RUN it also outranks a pending verdict.
  always_comb begin
    state_next = state;
    do_start   = 1'b0;
    do_finish  = 1'b0;
    do_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          do_start   = 1'b1;
        end
      end
      RUN: begin
        if (start) begin
          do_start = 1'b1;
        end else if (settled_a && settled_b) begin
          state_next = DONE;
          do_finish  = 1'b1;
        end else if (cyc == CYC_LAST) begin
          state_next = DONE;
          do_finish  = 1'b1;
          do_timeout = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          state_next = RUN;
          do_start   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      match         <= 1'b0;
      timeout       <= 1'b0;
      mismatch_mask <= '0;
      lat_a         <= '0;
      lat_b         <= '0;
      prev_a        <= '0;
      prev_b        <= '0;
      cyc           <= '0;
      chg_a         <= '0;
      chg_b         <= '0;
      stab_a        <= '0;
      stab_b        <= '0;
    end else begin
      busy <= (state_next == RUN);
      if (do_start) begin
        prev_a        <= cur_a;
        prev_b        <= cur_b;
        cyc           <= '0;
        chg_a         <= '0;
        chg_b         <= '0;
        stab_a        <= '0;
        stab_b        <= '0;
        done          <= 1'b0;
        match         <= 1'b0;
        timeout       <= 1'b0;
        mismatch_mask <= '0;
        lat_a         <= '0;
        lat_b         <= '0;
      end else if (do_finish) begin
        done          <= 1'b1;
        mismatch_mask <= mask_c;
        if (do_timeout) begin
          timeout <= 1'b1;
          match   <= 1'b0;
          lat_a   <= settled_a ? chg_a : '1;
          lat_b   <= settled_b ? chg_b : '1;
        end else begin
          match <= (mask_c == 4'b0000);
          lat_a <= chg_a;
          lat_b <= chg_b;
        end
      end else if (state == RUN) begin
        cyc    <= cyc + CNT_W'(1);
        prev_a <= cur_a;
        prev_b <= cur_b;
        // A settled array is frozen so later glitches cannot disturb its latency.
        if (!settled_a) begin
          if (cur_a != prev_a) begin
            stab_a <= '0;
            chg_a  <= cyc + CNT_W'(1);
          end else begin
            stab_a <= stab_a + STAB_W'(1);
          end
        end
        if (!settled_b) begin
          if (cur_b != prev_b) begin
            stab_b <= '0;
            chg_b  <= cyc + CNT_W'(1);
          end else begin
            stab_b <= stab_b + STAB_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_result_checker.sv
// Randomized self-checking bench for conv_result_checker: per-edge input sequences are
// planned up front and the verdict is predicted from those sequences with a window model.
module tb_conv_result_checker;

  localparam int unsigned DW      = 8;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned S       = 4;
  localparam int unsigned TIMEOUT = 200;
  localparam int          NS      = TIMEOUT + 8;

  logic             clk = 1'b0;
  logic             rst, start;
  logic [DW-1:0]    a_o00, a_o01, a_o10, a_o11;
  logic [DW-1:0]    b_o00, b_o01, b_o10, b_o11;
  logic             busy, done, match, timeout;
  logic [3:0]       mismatch_mask;
  logic [CNT_W-1:0] lat_a, lat_b;

  int checks = 0;
  int errors = 0;

  // Element k is what each window shows on the k-th clock edge after start (k=0: start edge).
  logic [31:0] sa [NS];
  logic [31:0] sb [NS];

  conv_result_checker #(.DW(DW), .CNT_W(CNT_W), .STABLE_CYCLES(S), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_o00(a_o00), .a_o01(a_o01), .a_o10(a_o10), .a_o11(a_o11),
    .b_o00(b_o00), .b_o01(b_o01), .b_o10(b_o10), .b_o11(b_o11),
    .busy(busy), .done(done), .match(match), .timeout(timeout),
    .mismatch_mask(mismatch_mask), .lat_a(lat_a), .lat_b(lat_b)
  );

  always #5 clk = ~clk;

  task automatic drive(input int k);
    {a_o00, a_o01, a_o10, a_o11} = sa[k];
    {b_o00, b_o01, b_o10, b_o11} = sb[k];
  endtask

  task automatic fill(input bit b, input int from, input logic [31:0] v);
    for (int k = from; k < NS; k++) begin
      if (b) sb[k] = v;
      else   sa[k] = v;
    end
  endtask

  task automatic toggle(input bit b, input int upto, input logic [31:0] p, input logic [31:0] q);
    for (int k = 0; k < upto; k++) begin
      if (b) sb[k] = k[0] ? p : q;
      else   sa[k] = k[0] ? p : q;
    end
  endtask

  function automatic logic [31:0] val(input bit b, input int k);
    return b ? sb[k] : sa[k];
  endfunction

  // First edge ending a window of S+1 identical samples.
  function automatic int settle_at(input bit b);
    for (int m = S; m < NS; m++) begin
      bit same = 1'b1;
      for (int j = m - S + 1; j <= m; j++)
        if (val(b, j) != val(b, j - 1)) same = 1'b0;
      if (same) return m;
    end
    return NS + 100;
  endfunction

  function automatic int last_change(input bit b, input int m);
    int r = 0;
    for (int j = 1; j <= m; j++)
      if (val(b, j) != val(b, j - 1)) r = j;
    return r;
  endfunction

  // Predicts the verdict from sa/sb, pulses start and follows the sequence until done.
  task automatic run_check(input string name);
    int ma, mb, mx, e, got;
    bit eto, ematch;
    logic [3:0] emask;
    logic [CNT_W-1:0] ela, elb;
    logic [31:0] va, vb;
    ma = settle_at(1'b0);
    mb = settle_at(1'b1);
    mx = (ma > mb) ? ma : mb;
    if (mx <= int'(TIMEOUT) - 1) begin e = mx + 1; eto = 1'b0; end
    else begin e = TIMEOUT; eto = 1'b1; end
    ela = (ma <= e - 1) ? CNT_W'(last_change(1'b0, ma)) : '1;
    elb = (mb <= e - 1) ? CNT_W'(last_change(1'b1, mb)) : '1;
    va = sa[e];
    vb = sb[e];
    emask = {va[7:0] != vb[7:0], va[15:8] != vb[15:8], va[23:16] != vb[23:16], va[31:24] != vb[31:24]};
    ematch = !eto && (emask == 4'b0000);

    @(negedge clk); start = 1'b1; drive(0);
    @(negedge clk); start = 1'b0; drive(1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_start got %b exp 1", name, busy); end
    got = -1;
    for (int k = 1; k < NS - 1; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin got = k; break; end
      drive(k + 1);
    end
    checks++;
    if (got != e) begin errors++; $display("FAIL %s done_edge got %0d exp %0d", name, got, e); end
    checks++;
    if (timeout !== eto) begin errors++; $display("FAIL %s timeout got %b exp %b", name, timeout, eto); end
    checks++;
    if (match !== ematch) begin errors++; $display("FAIL %s match got %b exp %b", name, match, ematch); end
    checks++;
    if (mismatch_mask !== emask) begin errors++; $display("FAIL %s mask got %b exp %b", name, mismatch_mask, emask); end
    checks++;
    if (lat_a !== ela) begin errors++; $display("FAIL %s lat_a got %0d exp %0d", name, lat_a, ela); end
    checks++;
    if (lat_b !== elb) begin errors++; $display("FAIL %s lat_b got %0d exp %0d", name, lat_b, elb); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done got %b exp 0", name, busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start = 1'(i);
      {a_o00, a_o01, a_o10, a_o11} = $urandom;
      {b_o00, b_o01, b_o10, b_o11} = $urandom;
    end
    @(negedge clk);
    checks++;
    if ({busy, done, match, timeout, mismatch_mask, lat_a, lat_b} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got b%b d%b m%b t%b mask%b la%0d lb%0d exp all 0",
               busy, done, match, timeout, mismatch_mask, lat_a, lat_b);
    end
    rst = 1'b0; start = 1'b0;
  endtask

  task automatic test_equal_settle();
    logic [31:0] t = 32'h0A141E28;
    fill(0, 0, $urandom | 32'h8000_0000); fill(1, 0, $urandom | 32'h8000_0000);
    fill(0, 3, t); fill(1, 3, t ^ 32'h0101_0101); fill(1, 5, t);
    run_check("equal_settle");
    checks++;
    if (lat_a !== 8'd3 || lat_b !== 8'd5) begin
      errors++; $display("FAIL equal_settle_lat got %0d/%0d exp 3/5", lat_a, lat_b);
    end
    // Verdict must hold as a level.
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1 || match !== 1'b1) begin
      errors++; $display("FAIL done_hold got d%b m%b exp d1 m1", done, match);
    end
  endtask

  task automatic test_mismatch();
    fill(0, 0, $urandom | 32'h8000_0000); fill(1, 0, $urandom | 32'h8000_0000);
    fill(0, 3, 32'h0A141E28); fill(1, 3, 32'h0B151F29); fill(1, 5, 32'h0A141F28);
    run_check("mismatch");
    checks++;
    if (mismatch_mask !== 4'b0100) begin
      errors++; $display("FAIL mismatch_o10 got %b exp 0100", mismatch_mask);
    end
  endtask

  task automatic test_timeout();
    fill(0, 0, 32'h1111_1111); fill(0, 1, 32'h2222_2222); fill(0, 2, 32'h3333_3333);
    toggle(1, NS, $urandom & 32'h7FFF_FFFF, $urandom | 32'h8000_0000);
    run_check("timeout");
    checks++;
    if (timeout !== 1'b1 || lat_a !== 8'd2 || lat_b !== 8'hFF) begin
      errors++; $display("FAIL timeout_fixed got t%b la%0d lb%0h exp t1 la2 lbFF", timeout, lat_a, lat_b);
    end
  endtask

  task automatic test_restart();
    @(negedge clk); start = 1'b1;
    {a_o00, a_o01, a_o10, a_o11} = $urandom; {b_o00, b_o01, b_o10, b_o11} = $urandom;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); start = 1'b0;
      {a_o00, a_o01, a_o10, a_o11} = $urandom; {b_o00, b_o01, b_o10, b_o11} = $urandom;
    end
    fill(0, 0, 32'h0102_0304); fill(0, 6, 32'h0506_0708);
    fill(1, 0, 32'h0A0B_0C0D); fill(1, 2, 32'h0506_0708);
    run_check("restart_in_run");
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || lat_a !== '0 || match !== 1'b0) begin
      errors++; $display("FAIL restart_in_done got d%b b%b la%0d m%b exp d0 b1 la0 m0", done, busy, lat_a, match);
    end
  endtask

  task automatic test_glitch_coincide();
    logic [31:0] g = 32'h4455_6677;
    fill(0, 0, 32'h0000_0001); fill(0, 1, 32'h0000_0002); fill(0, 2, g);
    sa[10] = g ^ 32'h0100_0000;
    fill(1, 0, 32'h9); fill(1, 3, 32'h19); fill(1, 8, 32'h29); fill(1, 15, g);
    run_check("glitch");
    checks++;
    if (lat_a !== 8'd2) begin errors++; $display("FAIL glitch_lat_a got %0d exp 2", lat_a); end
    toggle(0, TIMEOUT - 5, 32'h1, 32'h2); fill(0, TIMEOUT - 5, 32'h3);
    toggle(1, TIMEOUT - 5, 32'h4, 32'h5); fill(1, TIMEOUT - 5, 32'h3);
    run_check("coincide");
    checks++;
    if (timeout !== 1'b0 || lat_a !== CNT_W'(TIMEOUT - 5)) begin
      errors++; $display("FAIL coincide got t%b la%0d exp t0 la%0d", timeout, lat_a, TIMEOUT - 5);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int t, tb_last;
      fill(0, 0, $urandom);
      t = 0;
      for (int c = 0; c < int'($urandom_range(0, 4)); c++) begin
        t += $urandom_range(1, 45);
        if (t < NS) fill(0, t, $urandom);
      end
      fill(1, 0, $urandom);
      t = 0; tb_last = 0;
      for (int c = 0; c < int'($urandom_range(0, 4)); c++) begin
        t += $urandom_range(1, 45);
        if (t < NS) begin fill(1, t, $urandom); tb_last = t; end
      end
      if ($urandom_range(0, 1) == 1) begin
        logic [31:0] f = sa[NS - 1];
        if ($urandom_range(0, 1) == 1) f[8 * $urandom_range(0, 3) +: 8] ^= 8'h01;
        fill(1, tb_last, f);
      end
      if ($urandom_range(0, 9) == 0) toggle(1, NS, 32'hAAAA_AAAA, 32'h5555_5555);
      run_check($sformatf("random_%0d", it));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    {a_o00, a_o01, a_o10, a_o11} = '0;
    {b_o00, b_o01, b_o10, b_o11} = '0;
    test_reset();
    test_equal_settle();
    test_mismatch();
    test_timeout();
    test_restart();
    test_glitch_coincide();
    test_random();
    test_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_result_checker.md
Name: conv_result_checker

Overview:
- Downstream consumer of the 3x3 and 2x2 systolic convolution arrays. Sits beside the display.
- After the controller releases the arrays, it watches both 2x2 output windows until each has settled.
- It then records each array's latency in cycles and compares the two windows element by element.
- It produces done, match, timeout and mismatch indications for debug LEDs and the display.

Parameters:
- DW, 8, width of each output element.
- CNT_W, 8, width of the cycle counter and latency outputs.
- STABLE_CYCLES, 4, consecutive unchanged cycles required to declare an array settled (range 1..15).
- TIMEOUT, 200, cycle count at which the check aborts (must be < 2^CNT_W).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse from the controller, the cycle the arrays leave reset.
- a_o00, a_o01, a_o10, a_o11  in  DW each  3x3 array outputs.
- b_o00, b_o01, b_o10, b_o11  in  DW each  2x2 array outputs.
- busy  out  1  high while checking.
- done  out  1  high (level) once a verdict is latched.
- match  out  1  all four elements equal and no timeout.
- timeout  out  1  check aborted before both arrays settled.
- mismatch_mask  out  4  bit0=o00, bit1=o01, bit2=o10, bit3=o11; 1 = a != b.
- lat_a  out  CNT_W  settle latency of 3x3 array.
- lat_b  out  CNT_W  settle latency of 2x2 array.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- rst (sync, active-high) forces:
  - state IDLE;
  - all outputs 0;
  - internal counters 0;
  - prev_a and prev_b registers 0.
- States IDLE -> RUN -> DONE. DONE holds until the next start or rst.
- IDLE:
  - busy=0.
  - On start: prev_a<={a_o00,a_o01,a_o10,a_o11}, prev_b likewise; cyc<=0; stab_a<=0; stab_b<=0; chg_a<=0; chg_b<=0.
  - Clear done, match, timeout, mask, lat_a and lat_b.
  - Go to RUN.
- RUN (busy=1), every cycle:
  - cyc<=cyc+1.
  - For each array X: if current vector != prev_X then stab_X<=0 and chg_X<=cyc+1; else stab_X<=stab_X+1, saturating at STABLE_CYCLES. Then prev_X<=current.
  - settled_X = (stab_X == STABLE_CYCLES), registered value.
  - Once settled_X is true it stays true for the rest of the run, even if the inputs later change (late glitches are ignored). chg_X is frozen at that point.
- Exit from RUN:
  - If settled_a && settled_b, go to DONE next cycle: lat_a<=chg_a, lat_b<=chg_b, mask per element compare of current a vs b, match<=(mask==0), done<=1, busy<=0.
  - Else if cyc == TIMEOUT-1, go to DONE: timeout<=1, match<=0, done<=1. lat_X<=chg_X if settled_X, else all-ones. Mask is still computed from the current values.
  - If both conditions hit in the same cycle, settled wins and timeout=0.
- start while in RUN restarts the check: same actions as in IDLE, state stays RUN.
- start while in DONE clears the verdict and restarts: same cycle actions as IDLE.
- rst takes precedence over start.
- Latency definition: number of clocks after the start cycle at which the final value first appeared.
  - Example: a value that changes on the first and third post-start edges and is constant afterwards yields lat=3.
- Verdict timing: done rises STABLE_CYCLES+1 cycles after the later array's last change.
- Comparison is an unsigned DW-bit equality test.
- cyc never wraps, because TIMEOUT < 2^CNT_W.

Test Plan:
- Reset: assert rst for 2 cycles with random inputs -> busy, done, match, timeout, mask, lat_a and lat_b are all 0.
- Equal settle: start; a and b change to {10,20,30,40} at cycle 3; a stays; b also reaches {10,20,30,40} at cycle 5 -> done at cycle 10, match=1, mask=0, lat_a=3, lat_b=5.
- Mismatch: as above but b_o10 settles to 31 -> done=1, match=0, mask=4'b0100.
- Timeout: b toggles every cycle, a settles at cycle 2 -> done when cyc=TIMEOUT-1, timeout=1, match=0, lat_a=2, lat_b=8'hFF.
- Restart: start pulse mid-RUN at cycle 4 -> counters reset, latencies measured from the second start; start again in DONE -> done drops the next cycle and busy=1.
- Glitch after settle, plus coincidence: a settled, then a_o00 changes once while b is still settling -> the glitch is ignored and lat_a is unchanged. Both settle on cycle TIMEOUT-1 -> timeout=0.
